// File: rtl/log_div_pkg.sv
// log_div_pkg: widths, constants and stage records for the logarithmic divider
package log_div_pkg;
    localparam int OP_W     = 8;
    localparam int RES_W    = 16;
    localparam int FRAC_W   = 7;
    localparam int OUT_FRAC = 8;
    localparam int LOG_W    = 10;
    localparam int DIFF_W   = 11;
    localparam int MAG_W    = 17;
    localparam int K_W      = 3;
    localparam logic [RES_W-1:0] POS_MAX = 16'h7FFF;
    localparam logic [RES_W-1:0] NEG_MAX = 16'h8000;

    typedef struct packed {
        logic [LOG_W-1:0] l_a;
        logic [LOG_W-1:0] l_b;
        logic             sign;
        logic             a_zero;
        logic             b_zero;
        logic             vld;
    } s1_t;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             sign;
        logic             a_zero;
        logic             b_zero;
        logic             vld;
    } s2_t;
endpackage

// File: rtl/antilog_shifter.sv
// antilog_shifter: converts a log-domain difference into a Q8.8 magnitude
module antilog_shifter
    import log_div_pkg::*;
(
    input  logic [DIFF_W-1:0] d,
    output logic [MAG_W-1:0]  mag
);
    logic [4:0]       e;
    logic [3:0]       r;
    logic [MAG_W-1:0] base;
    // e = floor(d/128)+1 is the shift exponent; negative e shifts right and truncates
    always_comb begin
        e    = {d[DIFF_W-1], d[DIFF_W-1:FRAC_W]} + 5'd1;
        r    = 4'd0 - e[3:0];
        base = MAG_W'({1'b1, d[FRAC_W-1:0]});
        mag  = e[4] ? base >> r : base << e[3:0];
    end
endmodule

// File: rtl/lod.sv
// lod: leading-one position and left-aligned fraction below it
module lod
    import log_div_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    output logic [K_W-1:0]    k,
    output logic [FRAC_W-1:0] f
);
    // highest set bit wins; shifting the low bits left pushes the leading one out of the field
    always_comb begin
        k = '0;
        for (int i = 0; i < OP_W; i++)
            if (x[i]) k = K_W'(i);
        f = x[FRAC_W-1:0] << (K_W'(OP_W - 1) - k);
    end
endmodule

// File: rtl/log_divider.sv
// log_divider: three-stage Mitchell log-domain signed 8-bit divider, Q8.8 quotient
module log_divider
    import log_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             div_by_zero
);
    s1_t               s1, s1_d;
    s2_t               s2, s2_d;
    logic [OP_W-1:0]   abs_a, abs_b;
    logic [K_W-1:0]    k_a, k_b;
    logic [FRAC_W-1:0] f_a, f_b;
    logic [DIFF_W-1:0] diff;
    logic [MAG_W-1:0]  mag;
    logic [RES_W-1:0]  pos, neg, res_d;
    logic              stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign abs_a    = A[OP_W-1] ? -A : A;
    assign abs_b    = B[OP_W-1] ? -B : B;
    assign diff     = {1'b0, s1.l_a} - {1'b0, s1.l_b};

    lod u_lod_a (.x(abs_a), .k(k_a), .f(f_a));
    lod u_lod_b (.x(abs_b), .k(k_b), .f(f_b));
    antilog_shifter u_antilog (.d(diff), .mag(mag));

    // next contents of each stage, including saturation and sign application at the output
    always_comb begin
        s1_d  = '{l_a: {k_a, f_a}, l_b: {k_b, f_b}, sign: A[OP_W-1] ^ B[OP_W-1],
                  a_zero: A == '0, b_zero: B == '0, vld: in_valid};
        s2_d  = '{mag: mag, sign: s1.sign, a_zero: s1.a_zero, b_zero: s1.b_zero, vld: s1.vld};
        pos   = s2.mag > MAG_W'(POS_MAX) ? POS_MAX : s2.mag[RES_W-1:0];
        neg   = s2.mag >= MAG_W'(NEG_MAX) ? NEG_MAX : -s2.mag[RES_W-1:0];
        res_d = (s2.b_zero || s2.a_zero) ? '0 : s2.sign ? neg : pos;
    end

    // whole pipeline advances together unless the output is held by the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (!stall) begin
            s1          <= s1_d;
            s2          <= s2_d;
            out_valid   <= s2.vld;
            result      <= res_d;
            div_by_zero <= s2.b_zero;
        end
    end
endmodule

// File: tb/tb_log_divider.sv
// tb_log_divider: directed self-checking bench for the logarithmic divider
module tb_log_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        div_by_zero;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    log_divider dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (result !== 16'h0) $display("FAIL reset_result got=%h exp=0000", result); else passed++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_latency(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_res, input string name);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== (e == 3))
                $display("FAIL %s_latency edge=%0d got=%b exp=%b", name, e, out_valid, e == 3);
            else passed++;
        end
        total++; if (result !== exp_res) $display("FAIL %s_result got=%h exp=%h", name, result, exp_res); else passed++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL %s_dbz got=%b exp=0", name, div_by_zero); else passed++;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [7:0]  va [10] = '{8'd1, 8'd127, 8'h80, 8'h80, 8'hFA, 8'd5, 8'd0, 8'd0, 8'd7, 8'hFF};
        logic [7:0]  vb [10] = '{8'd127, 8'd1, 8'd1, 8'hFF, 8'd3, 8'd0, 8'd7, 8'd0, 8'hF9, 8'd2};
        logic [15:0] er [10] = '{16'h0002, 16'h7F00, 16'h8000, 16'h7FFF, 16'hFE00,
                                 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'hFF80};
        logic        ez [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            A = va[i]; B = vb[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            w = 0;
            while (!out_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            total++; if (out_valid !== 1'b1) $display("FAIL vec%0d_timeout got=%b exp=1", i, out_valid); else passed++;
            total++; if (result !== er[i]) $display("FAIL vec%0d_result A=%0d B=%0d got=%h exp=%h", i, $signed(va[i]), $signed(vb[i]), result, er[i]); else passed++;
            total++; if (div_by_zero !== ez[i]) $display("FAIL vec%0d_dbz got=%b exp=%b", i, div_by_zero, ez[i]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  va [6] = '{8'd100, 8'd127, 8'hFA, 8'd7, 8'hFF, 8'd1};
        logic [7:0]  vb [6] = '{8'd10, 8'd1, 8'd3, 8'hF9, 8'd2, 8'd127};
        logic [15:0] er [6] = '{16'h0A80, 16'h7F00, 16'hFE00, 16'hFF00, 16'hFF80, 16'h0002};
        int          sent = 0;
        int          got = 0;
        int          hold = 0;
        logic        held = 1'b0;
        logic        ov;
        logic [15:0] held_res = '0;
        for (int c = 0; c < 40; c++) begin
            ov = out_valid;
            if (ov && !held) begin
                held = 1'b1;
                hold = 4;
                held_res = result;
            end
            out_ready = (hold == 0);
            if (hold > 0) hold--;
            in_valid = (sent < 6);
            A = va[sent % 6]; B = vb[sent % 6];
            #1;
            if (!out_ready) begin
                total++; if (in_ready !== 1'b0) $display("FAIL b2b_hold_in_ready cycle=%0d got=%b exp=0", c, in_ready); else passed++;
                total++; if (result !== held_res) $display("FAIL b2b_hold_result cycle=%0d got=%h exp=%h", c, result, held_res); else passed++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (got >= 6) $display("FAIL b2b_extra_result got=%0d exp=6", got + 1);
                else if (result !== er[got] || div_by_zero !== 1'b0)
                    $display("FAIL b2b_result%0d got=%h/%b exp=%h/0", got, result, div_by_zero, er[got]);
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (got !== 6) $display("FAIL b2b_count got=%0d exp=6", got); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] va [3] = '{8'd100, 8'd127, 8'hFA};
        logic [7:0] vb [3] = '{8'd10, 8'd1, 8'd3};
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = va[i]; B = vb[i]; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (result !== 16'h0) $display("FAIL midrst_result got=%h exp=0000", result); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL midrst_ghosts got=%0d exp=0", seen); else passed++;
        test_latency(8'd127, 8'd1, 16'h7F00, "post_rst");
    endtask

    initial begin
        test_reset();
        test_latency(8'd100, 8'd10, 16'h0A80, "div100_10");
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/log_divider.md
Name: log_divider

Overview:
- Pipelined signed 8-bit divider using Mitchell's logarithmic approximation. It is the inverse-direction companion of the log-domain multiplier.
- Datapath: sign detect, leading-one detect, log convert, log subtract, antilog shift, sign set.
- Produces a signed Q8.8 quotient with a valid/ready handshake on both sides. Sits beside the multiplier in the approximate-arithmetic datapath.

Parameters:
- None. Widths are fixed: 8-bit two's-complement operands, 16-bit Q8.8 quotient. All widths and constants come from the package.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair A/B presented
- in_ready  output  1  block can accept an operand pair this cycle
- A  input  8  signed dividend
- B  input  8  signed divisor
- out_valid  output  1  result/div_by_zero valid
- out_ready  input  1  consumer accepts the result this cycle
- result  output  16  signed Q8.8 quotient
- div_by_zero  output  1  B was 0 for this result

Behaviour:
- Reset: while rst=1, all pipeline valid bits, out_valid, result and div_by_zero are 0. in_ready is 1 once rst deasserts. Any in-flight data is discarded when rst asserts mid-operation; no partial result emerges afterwards.
- Handshakes: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !stall. On a stall every stage holds its contents, and result/div_by_zero stay stable.
- Latency: a pair accepted at clock edge t gives out_valid=1 after edge t+3, with no stalls. Throughput is 1 per cycle, and results leave in order.
- Bubbles: idle cycles travel as invalid stages. No compaction is required.
- S1 (register at edge 1):
  - sign = A[7]^B[7]; |A|, |B| as 8-bit unsigned (|-128| = 128).
  - LOD: k = index of the leading one (0..7); f = 7-bit fraction = bits below the leading one, left-aligned.
  - L = k*128 + f, 10 bits unsigned.
  - Register L_A, L_B, sign, a_zero = (A==0), b_zero = (B==0).
- S2 (register at edge 2):
  - D = L_A - L_B, 11-bit signed, range -1023..1023.
  - n = D >>> 7 (floor, -8..7); g = D[6:0].
  - mag = (128+g) << (n+1) when n >= -1, else (128+g) >> (-(n+1)). Right shifts truncate.
  - mag is 17 bits unsigned, in 1/256 units.
- S3 (register at edge 3):
  - b_zero: result = 0, div_by_zero = 1.
  - Else a_zero: result = 0, div_by_zero = 0.
  - Else if sign = 0: result = min(mag, 0x7FFF).
  - Else: result = -min(mag, 0x8000).
- Saturation: n = 7 occurs only for |A| = 128 and |B| = 1, which gives mag = 32768. Positive saturates to 0x7FFF; negative is exactly 0x8000.
- Simultaneous input and output transfer in the same cycle is legal, with no bubble inserted.

Decomposition:
- Package log_div_pkg:
  - OP_W = 8, RES_W = 16, FRAC_W = 7, OUT_FRAC = 8, LOG_W = 10, DIFF_W = 11, MAG_W = 17.
  - Typedef for the S1 stage record: L_A, L_B, sign, a_zero, b_zero, vld.
  - Typedef for the S2 stage record: mag, sign, a_zero, b_zero, vld.
- Sub-module antilog_shifter: combinational D(11) to mag(17), per the S2 rule.
- The existing lod block is instantiated twice in S1.

Test Plan:
- A=100, B=10 (L_A=840, L_B=416, D=424, n=3, g=40) -> result=0x0A80, div_by_zero=0, out_valid exactly 3 cycles after acceptance.
- A=1, B=127 (D=-894, n=-7, g=2) -> result=0x0002. A=127, B=1 -> result=0x7F00.
- A=-128, B=1 -> 0x8000. A=-128, B=-1 -> 0x7FFF (saturated). A=-6, B=3 -> 0xFE00.
- A=5, B=0 -> result=0x0000, div_by_zero=1. A=0, B=7 -> result=0x0000, div_by_zero=0. A=0, B=0 -> div_by_zero=1.
- Stream 6 back-to-back pairs; hold out_ready=0 for 4 cycles after the first out_valid. Required: in_ready=0 during the hold, result stable, all 6 results delivered in order with no loss or duplication.
- Assert rst for 1 cycle with 3 pairs in flight -> out_valid=0 immediately; none of those 3 pairs appears afterwards. The next pair accepted produces a correct result at 3-cycle latency.
